// File: rtl/fir_pkg.sv
`default_nettype none
// =====================================================================
// Module : fir_pkg
// Brief  : Shared FSM encoding and default sizing for the FIR output streamer.
// Rev    : 1.0 - initial release
// =====================================================================
package fir_pkg;

  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_stream_if.sv
`default_nettype none
// =====================================================================
// Module : fir_out_stream_if
// Brief  : AXI-Stream style result channel with master/slave views.
// Rev    : 1.0 - initial release
// =====================================================================
interface fir_out_stream_if
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = c_DEF_DATA_WIDTH
) ();

  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    output sm_tvalid,
    output sm_tdata,
    output sm_tlast,
    input  sm_tready
  );

  modport slave (
    input  sm_tvalid,
    input  sm_tdata,
    input  sm_tlast,
    output sm_tready
  );

endinterface
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// =====================================================================
// Module : fir_sync_fifo
// Brief  : Power-of-two synchronous FIFO with a pop-aware head peek port.
// Rev    : 1.0 - initial release
// =====================================================================
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int DEPTH      = c_DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop,
  output logic [DATA_WIDTH-1:0]             peek_data,
  output logic                              full,
  output logic                              empty,
  output logic [fifo_cnt_width(DEPTH)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Head as it will be after this edge's pop, read before this edge's write.
  assign peek_data = mem_q[rd_ptr_d];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_out_stream.sv
`default_nettype none
// =====================================================================
// Module : fir_out_stream
// Brief  : Frames FIR core results into an AXI-Stream with tlast and back-pressure.
//          Optional sticky overflow accounting: define FIR_OUT_OVF_STICKY_EN.
// Rev    : 1.0 - initial release
// =====================================================================
module fir_out_stream
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = c_DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [pDATA_WIDTH-1:0] core_result,
  input  logic                   result_vld,
  input  logic                   start,
  input  logic [31:0]            data_length,
  fir_out_stream_if.master       axis,
  output logic                   core_stall,
  output logic                   done,
  output logic [31:0]            out_count,
  output logic                   ovf
);

  localparam int CW = fifo_cnt_width(FIFO_DEPTH);

  fir_state_e             state_q, state_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            res_cnt_q, res_cnt_d;
  logic [31:0]            out_count_q, out_count_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [pDATA_WIDTH-1:0] tdata_q, tdata_d;

  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count, fifo_left;
  logic [pDATA_WIDTH-1:0] fifo_peek;

  logic                   handshake, in_run, start_ok, push, res_taken;

  assign handshake = tvalid_q & axis.sm_tready;
  assign in_run    = (state_q == ST_RUN);
  assign start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign push      = in_run & result_vld & (~fifo_full | handshake);

  fir_sync_fifo #(
    .DATA_WIDTH (pDATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (core_result),
    .pop       (handshake),
    .peek_data (fifo_peek),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef FIR_OUT_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // Refused results still consume a slot of the frame so the frame length holds.
  assign res_taken = in_run & result_vld;

  always_comb begin
    ovf_d = ovf_q;
    if (start_ok) begin
      ovf_d = 1'b0;
    end else if (in_run & result_vld & fifo_full & ~handshake) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign res_taken = push;
  assign ovf       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    res_cnt_d   = res_cnt_q;
    out_count_d = out_count_q + {31'd0, handshake};
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          len_d       = data_length;
          res_cnt_d   = 32'd0;
          out_count_d = 32'd0;
          state_d     = (data_length != 32'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (res_taken) begin
          res_cnt_d = res_cnt_q + 32'd1;
          if (res_cnt_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Second term ends a frame whose tlast beat was lost to an overflow drop.
        if ((handshake & tlast_q) | (~tvalid_q & fifo_empty)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register shows the FIFO head left after this edge's pop; this
  // edge's push only becomes visible one cycle later.
  assign fifo_left = fifo_count - CW'(handshake);

  always_comb begin
    tvalid_d = (fifo_left != '0);
    tdata_d  = tvalid_d ? fifo_peek : tdata_q;
    tlast_d  = tvalid_d & (out_count_d == (len_d - 32'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= 32'd0;
      res_cnt_q   <= 32'd0;
      out_count_q <= 32'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      res_cnt_q   <= res_cnt_d;
      out_count_q <= out_count_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
    end
  end

  assign axis.sm_tvalid = tvalid_q;
  assign axis.sm_tdata  = tdata_q;
  assign axis.sm_tlast  = tlast_q;
  assign core_stall     = (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign done           = (state_q == ST_DONE);
  assign out_count      = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_stream.sv
`default_nettype none
// tb_fir_out_stream: directed and randomized frames checked against a
// queue-based frame model of the output streamer.
module tb_fir_out_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef FIR_OUT_OVF_STICKY_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic          result_vld  = 1'b0;
  logic          start       = 1'b0;
  logic [31:0]   data_length = 32'd0;
  logic          core_stall, done, ovf;
  logic [31:0]   out_count;

  fir_out_stream_if #(.pDATA_WIDTH(DW)) axis ();

  fir_out_stream #(.pDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_result (core_result),
    .result_vld  (result_vld),
    .start       (start),
    .data_length (data_length),
    .axis        (axis),
    .core_stall  (core_stall),
    .done        (done),
    .out_count   (out_count),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame model: queue of results held downstream of the core, plus frame counters.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] seen[$];
  bit            m_active = 1'b0;
  bit            m_ovf    = 1'b0;
  int unsigned   m_len = 0, m_acc = 0, m_beats = 0, m_dropc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    seen.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    m_len    = 0;
    m_acc    = 0;
    m_beats  = 0;
    m_dropc  = 0;
  endtask

  // One clock: drive inputs, advance the model on the pre-edge view, check after the edge.
  task automatic cycle(input bit vld, input logic [DW-1:0] d, input bit rdy,
                       input bit st, input logic [31:0] len);
    bit hs, acc;
    result_vld     = vld;
    core_result    = d;
    axis.sm_tready = rdy;
    start          = st;
    data_length    = len;
    hs = axis.sm_tvalid && rdy;
    if (hs) begin
      chk("beat_queued", m_q.size() != 0, 1'b1);
      if (m_q.size() != 0) begin
        chk("beat_data", axis.sm_tdata, m_q[0]);
        chk("beat_last", axis.sm_tlast, (m_beats + 1) == m_len);
        void'(m_q.pop_front());
      end
      seen.push_back(axis.sm_tdata);
      m_beats++;
    end
    if (st && !m_active) begin
      m_len    = len;
      m_acc    = 0;
      m_beats  = 0;
      m_dropc  = 0;
      m_ovf    = 1'b0;
      m_active = (len != 0);
      seen.delete();
    end else if (vld && m_active) begin
      acc = (m_q.size() < DEPTH) || hs;
      if (acc) m_q.push_back(d);
      else if (OVF_EN) begin
        m_ovf = 1'b1;
        m_dropc++;
      end
      if (acc || OVF_EN) m_acc++;
      if (m_acc == m_len) m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("core_stall", core_stall, m_q.size() >= DEPTH - 1);
    chk("out_count", out_count, m_beats);
    chk("ovf", ovf, m_ovf);
    if (axis.sm_tvalid) begin
      chk("valid_has_item", m_q.size() != 0, 1'b1);
      if (m_q.size() != 0) chk("head_data", axis.sm_tdata, m_q[0]);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0, 32'd0);
  endtask

  task automatic drain(input int budget, input bit rand_ready);
    int k = 0;
    while (!done && k < budget) begin
      cycle(1'b0, '0, rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1, 1'b0, 32'd0);
      k++;
    end
    chk("drain_done", done, 1'b1);
    chk("drain_empty", m_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] d [6];
    logic [31:0]   len;
    int            k;

    axis.sm_tready = 1'b0;
    model_clear();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", axis.sm_tvalid, 1'b0);
    chk("rst_tdata", axis.sm_tdata, 32'd0);
    chk("rst_tlast", axis.sm_tlast, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", out_count, 32'd0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // Basic three-result frame with latency check
    cycle(1'b0, '0, 1'b1, 1'b1, 32'd3);
    cycle(1'b1, 32'h11, 1'b1, 1'b0, 32'd0);
    chk("lat_edge_n", axis.sm_tvalid, 1'b0);
    cycle(1'b1, 32'h22, 1'b1, 1'b0, 32'd0);
    chk("lat_edge_n1_valid", axis.sm_tvalid, 1'b1);
    chk("lat_edge_n1_data", axis.sm_tdata, 32'h11);
    cycle(1'b1, 32'h33, 1'b1, 1'b0, 32'd0);
    drain(50, 1'b0);
    chk("basic_nbeats", seen.size(), 3);
    chk("basic_b0", seen[0], 32'h11);
    chk("basic_b1", seen[1], 32'h22);
    chk("basic_b2", seen[2], 32'h33);
    chk("basic_count", out_count, 32'd3);

    // Back-pressure: fill to full, hold the head, then push and pop at full
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    cycle(1'b0, '0, 1'b0, 1'b1, 32'd6);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, d[i], 1'b0, 1'b0, 32'd0);
      chk("stall_level", core_stall, i >= 2);
      if (i >= 1) begin
        chk("hold_valid", axis.sm_tvalid, 1'b1);
        chk("hold_first", axis.sm_tdata, d[0]);
      end
    end
    cycle(1'b1, d[4], 1'b1, 1'b0, 32'd0);
    chk("full_pushpop_stall", core_stall, 1'b1);
    chk("full_pushpop_ovf", ovf, 1'b0);
    cycle(1'b1, d[5], 1'b1, 1'b0, 32'd0);
    drain(50, 1'b0);
    chk("bp_nbeats", seen.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", seen[i], d[i]);

    // Fifth result against a full FIFO with ready low
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    cycle(1'b0, '0, 1'b0, 1'b1, 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b1, d[i], 1'b0, 1'b0, 32'd0);
    chk("drop_ovf", ovf, OVF_EN);
    idle(6, 1'b1);
    chk("drop_frame_done", done, OVF_EN);
    if (!done) cycle(1'b1, d[5], 1'b1, 1'b0, 32'd0);
    drain(50, 1'b0);
    chk("drop_frame_beats", out_count, OVF_EN ? 32'd4 : 32'd5);
    chk("drop_first", seen[0], d[0]);
    chk("drop_fourth", seen[3], d[3]);

    // Start during RUN must not restart the frame
    cycle(1'b0, '0, 1'b1, 1'b1, 32'd2);
    cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'd7);
    cycle(1'b1, 32'hA5A5_0002, 1'b1, 1'b0, 32'd0);
    drain(50, 1'b0);
    chk("ign_start_count", out_count, 32'd2);
    chk("ign_start_b1", seen[1], 32'hA5A5_0002);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 12);
      cycle(1'b0, '0, 1'b1, 1'b1, len);
      k = 0;
      while (m_active && k < 400) begin
        cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0, 1'b0, 32'd0);
        k++;
      end
      chk("rand_run_budget", m_active, 1'b0);
      drain(400, 1'b1);
      chk("rand_frame_beats", out_count, len - m_dropc);
    end

    // Reset asserted mid-DRAIN
    cycle(1'b0, '0, 1'b0, 1'b1, 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_valid", axis.sm_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", axis.sm_tvalid, 1'b0);
    chk("mid_rst_stall", core_stall, 1'b0);
    chk("mid_rst_count", out_count, 32'd0);
    chk("mid_rst_done", done, 1'b0);
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4, 1'b1);
    chk("post_rst_done", done, 1'b0);

    // Zero-length frame from IDLE
    cycle(1'b0, '0, 1'b1, 1'b1, 32'd0);
    chk("zero_len_done", done, 1'b1);
    chk("zero_len_valid", axis.sm_tvalid, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
    chk("zero_len_no_beat", axis.sm_tvalid, 1'b0);
    chk("zero_len_count", out_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fir_out_stream.md
FIR_OUT_STREAM -- requirements
Module: fir_out_stream

Interface
REQ-001 Parameter pDATA_WIDTH, default 32, SHALL set the result and stream data width.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the output buffer depth; a power of two, at least 2.
REQ-003 clk  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 core_result  in  pDATA_WIDTH  SHALL carry the filter output sum from the core.
REQ-006 result_vld  in  1  SHALL be a single-cycle strobe marking core_result as valid.
REQ-007 start  in  1  SHALL be a single-cycle pulse that begins a frame.
REQ-008 data_length  in  32  SHALL give the number of results in a frame, sampled when start is high.
REQ-009 sm_tready  in  1  SHALL be the downstream AXI-Stream ready signal.
REQ-010 sm_tvalid, sm_tdata[pDATA_WIDTH], sm_tlast  out  SHALL form the AXI-Stream master output.
REQ-011 core_stall  out  1  SHALL request the core to pause; high when FIFO occupancy >= FIFO_DEPTH-1.
REQ-012 done  out  1  SHALL be high in state DONE.
REQ-013 out_count  out  32  SHALL give the number of beats transferred in the current frame.
REQ-014 ovf  out  1  SHALL be a sticky overflow flag (see Configuration).

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE or DONE with start=1: if data_length != 0 the FSM SHALL go to RUN; if data_length == 0 it SHALL go to DONE.
REQ-017 In RUN, the block SHALL push core_result into the FIFO in the cycle result_vld=1, provided the FIFO is not full or a pop occurs in the same cycle.
REQ-018 When the accepted-result count reaches data_length, RUN SHALL go to DRAIN; further result_vld in DRAIN, DONE or IDLE SHALL be ignored.
REQ-019 DRAIN SHALL go to DONE in the cycle after the handshake of the beat carrying sm_tlast.
REQ-020 sm_tvalid SHALL be registered; a result pushed into an empty FIFO at edge N SHALL appear on sm_tdata with sm_tvalid=1 after edge N+1.
REQ-021 A pop SHALL occur only when sm_tvalid and sm_tready are both 1.
REQ-022 sm_tdata and sm_tlast SHALL hold stable while sm_tvalid=1 and sm_tready=0.
REQ-023 sm_tlast SHALL be 1 only on the beat where out_count == data_length-1.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 When push and pop occur in the same cycle, occupancy SHALL be unchanged.
REQ-026 out_count SHALL increment on each handshake and clear on start.
REQ-027 Data SHALL pass through unmodified; the block SHALL perform no arithmetic on the data path.
REQ-028 A start pulse in RUN or DRAIN SHALL be ignored.

Reset
REQ-029 While rst_n=0: state=IDLE, FIFO empty, sm_tvalid=0, sm_tdata=0, sm_tlast=0, core_stall=0, done=0, out_count=0, ovf=0.
REQ-030 Reset asserted mid-frame SHALL discard buffered data with no further beats emitted.
REQ-031 The FSM SHALL leave IDLE only on start.

Configuration
REQ-032 Macro FIR_OUT_OVF_STICKY_EN: when defined, a result_vld in RUN that is refused because the FIFO is full SHALL set ovf until the next start, and the dropped result SHALL still count toward data_length.
REQ-033 Without FIR_OUT_OVF_STICKY_EN, a refused result SHALL be dropped silently without counting toward data_length, and ovf SHALL be constant 0.

Structure
REQ-034 The FSM state encoding and the default depth/width constants SHALL live in the shared package fir_pkg.
REQ-035 The FIFO SHALL be a sub-module named fir_sync_fifo (push, pop, full, empty, count); the FSM, counters and tlast logic SHALL stay in fir_out_stream.

Verification
REQ-036 Reset, then start with data_length=3, three results (0x11, 0x22, 0x33) with sm_tready=1 -> beats 0x11, 0x22, 0x33; tlast only on 0x33; done=1; out_count=3.
REQ-037 sm_tready=0 with four results pushed (FIFO_DEPTH=4) -> core_stall=1 once occupancy reaches 3; sm_tdata stays 0x..first; releasing ready drains the results in order.
REQ-038 FIFO full with simultaneous push and pop -> no drop, occupancy stays 4, ovf=0.
REQ-039 Fifth result with the FIFO full and ready=0 -> with macro: ovf=1 and the frame still ends after data_length; without macro: ovf=0 and the frame needs an extra result.
REQ-040 start with data_length=0 -> DONE the next cycle, no beats; reset asserted mid-DRAIN -> sm_tvalid=0 immediately, state IDLE.
